// File: rtl/riscv_pipe_pkg.sv
// Purpose: shared types and widths for the RISC-V pipeline memory stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pipe_pkg;

    localparam int XLEN                 = 32;
    localparam int REG_ADDR_W           = 5;
    localparam int TIMEOUT_CYCLES_DEF   = 16;

    // Data-memory access FSM
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic                  regwrite;
        logic                  resultsrc;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       pcplus4;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       readdata;
    } mem_wb_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Purpose: data-memory access FSM, pipeline stall and optional timeout (MEM_TIMEOUT_EN).
// Latency: combinational stall/timeout; FSM state updates on the next clk edge.
// Backpressure: stall_m stays high while an access waits on dmem_ready.
module mem_access_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
    input  logic clk,
    input  logic rst,
    input  logic access,
    input  logic dmem_ready,
    output logic stall_m,
    output logic timeout,
    output logic mem_err
);

    mem_state_e state_q;
    mem_state_e state_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             mem_err_q;

    // The abandon cycle is the one where this WAIT cycle brings the count to TIMEOUT_CYCLES.
    assign timeout = (state_q == WAIT) && access && !dmem_ready
                     && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count WAIT cycles; any return to IDLE restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_d == IDLE) begin
            cnt_q <= '0;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_err_q <= 1'b0;
        end else if (timeout) begin
            mem_err_q <= 1'b1;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Upstream is frozen while stalled; the abandon cycle releases it.
    assign stall_m = access && !dmem_ready && !timeout;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: wait for dmem_ready, or give up on timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (access && !dmem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ready || !access || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// Purpose: RISC-V M stage: drives data memory, registers MEM/WB state (timeout via MEM_TIMEOUT_EN).
// Latency: 1 cycle M->W when dmem_ready is high in the request cycle; +1 per wait cycle.
// Backpressure: stall_m freezes upstream and loads a bubble into W while memory is not ready.
module memory_cycle
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regwritem,
    input  logic                  memwritem,
    input  logic                  resultsrcm,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [XLEN-1:0]       pcplus4m,
    input  logic [XLEN-1:0]       writedatam,
    input  logic [XLEN-1:0]       alu_resultm,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  stall_m,
    output logic                  regwritew,
    output logic                  resultsrcw,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic [XLEN-1:0]       pcplus4w,
    output logic [XLEN-1:0]       alu_resultw,
    output logic [XLEN-1:0]       readdataw,
    output logic                  mem_err
);

    logic    access;
    logic    timeout;
    mem_wb_t wb_q;

    assign access     = memwritem | resultsrcm;
    assign dmem_req   = access;
    assign dmem_we    = memwritem;
    assign dmem_addr  = alu_resultm;
    assign dmem_wdata = writedatam;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .access     (access),
        .dmem_ready (dmem_ready),
        .stall_m    (stall_m),
        .timeout    (timeout),
        .mem_err    (mem_err)
    );

    // MEM/WB register: bubble while stalled; an abandoned access never writes back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q <= '0;
        end else if (stall_m) begin
            wb_q <= '0;
        end else begin
            wb_q.regwrite   <= regwritem & ~timeout;
            wb_q.resultsrc  <= resultsrcm;
            wb_q.rd         <= rd_m;
            wb_q.pcplus4    <= pcplus4m;
            wb_q.alu_result <= alu_resultm;
            wb_q.readdata   <= (resultsrcm && !timeout) ? dmem_rdata : '0;
        end
    end

    assign regwritew   = wb_q.regwrite;
    assign resultsrcw  = wb_q.resultsrc;
    assign rd_w        = wb_q.rd;
    assign pcplus4w    = wb_q.pcplus4;
    assign alu_resultw = wb_q.alu_result;
    assign readdataw   = wb_q.readdata;

endmodule

// File: tb/tb_memory_cycle.sv
// Purpose: directed self-checking bench for memory_cycle (timeout case under MEM_TIMEOUT_EN).
// Latency: inputs change 1ns after posedge; comb checks 3ns after, W checks 1ns after next posedge.
// Backpressure: dmem_ready driven directly by the vectors.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwritem, memwritem, resultsrcm;
    logic [4:0]  rd_m;
    logic [31:0] pcplus4m, writedatam, alu_resultm;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall_m, regwritew, resultsrcw;
    logic [4:0]  rd_w;
    logic [31:0] pcplus4w, alu_resultw, readdataw;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_cycle #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .regwritem   (regwritem),
        .memwritem   (memwritem),
        .resultsrcm  (resultsrcm),
        .rd_m        (rd_m),
        .pcplus4m    (pcplus4m),
        .writedatam  (writedatam),
        .alu_resultm (alu_resultm),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .stall_m     (stall_m),
        .regwritew   (regwritew),
        .resultsrcw  (resultsrcw),
        .rd_w        (rd_w),
        .pcplus4w    (pcplus4w),
        .alu_resultw (alu_resultw),
        .readdataw   (readdataw),
        .mem_err     (mem_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu,
                         input logic rdy, input logic [31:0] rdata);
        regwritem   = rw;
        memwritem   = mw;
        resultsrcm  = rs;
        rd_m        = rd;
        pcplus4m    = pc;
        writedatam  = wd;
        alu_resultm = alu;
        dmem_ready  = rdy;
        dmem_rdata  = rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        #3;
        check_eq("rst_regwritew", {31'b0, regwritew}, 32'h0);
        check_eq("rst_alu_resultw", alu_resultw, 32'h0);
        check_eq("rst_mem_err", {31'b0, mem_err}, 32'h0);
        check_eq("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ALU op: no request, one-cycle pass-through
        drive(1, 0, 0, 5'd5, 32'h1004, 32'h0, 32'h2A, 0, 32'h0);
        #2;
        check_eq("alu_req", {31'b0, dmem_req}, 32'h0);
        check_eq("alu_stall", {31'b0, stall_m}, 32'h0);
        tick();
        check_eq("alu_rd_w", {27'b0, rd_w}, 32'd5);
        check_eq("alu_resultw", alu_resultw, 32'h2A);
        check_eq("alu_regwritew", {31'b0, regwritew}, 32'h1);
        check_eq("alu_pcplus4w", pcplus4w, 32'h1004);

        // Load, ready immediately
        drive(1, 0, 1, 5'd7, 32'h1008, 32'h0, 32'h100, 1, 32'hDEADBEEF);
        #2;
        check_eq("ld_stall", {31'b0, stall_m}, 32'h0);
        check_eq("ld_req", {31'b0, dmem_req}, 32'h1);
        check_eq("ld_we", {31'b0, dmem_we}, 32'h0);
        check_eq("ld_addr", dmem_addr, 32'h100);
        tick();
        check_eq("ld_readdataw", readdataw, 32'hDEADBEEF);
        check_eq("ld_resultsrcw", {31'b0, resultsrcw}, 32'h1);
        check_eq("ld_rd_w", {27'b0, rd_w}, 32'd7);

        // Back-to-back store, ready delayed 3 cycles
        drive(0, 1, 0, 5'd0, 32'h100C, 32'h55, 32'h104, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #2;
            check_eq("st_wait_stall", {31'b0, stall_m}, 32'h1);
            check_eq("st_wait_addr", dmem_addr, 32'h104);
            check_eq("st_wait_wdata", dmem_wdata, 32'h55);
            check_eq("st_wait_we", {31'b0, dmem_we}, 32'h1);
            tick();
            check_eq("st_bubble_pcplus4w", pcplus4w, 32'h0);
            check_eq("st_bubble_regwritew", {31'b0, regwritew}, 32'h0);
        end
        dmem_ready = 1'b1;
        #2;
        check_eq("st_done_stall", {31'b0, stall_m}, 32'h0);
        check_eq("st_done_we", {31'b0, dmem_we}, 32'h1);
        tick();
        check_eq("st_alu_resultw", alu_resultw, 32'h104);
        check_eq("st_pcplus4w", pcplus4w, 32'h100C);
        check_eq("st_regwritew", {31'b0, regwritew}, 32'h0);
        check_eq("st_readdataw", readdataw, 32'h0);

        // dmem_ready with no access is ignored
        drive(1, 0, 0, 5'd9, 32'h1010, 32'h0, 32'h33, 1, 32'hFFFFFFFF);
        #2;
        check_eq("idle_rdy_stall", {31'b0, stall_m}, 32'h0);
        tick();
        check_eq("idle_rdy_readdataw", readdataw, 32'h0);
        check_eq("idle_rdy_rd_w", {27'b0, rd_w}, 32'd9);

        // Reset while waiting
        drive(1, 0, 1, 5'd10, 32'h1014, 32'h0, 32'h300, 0, 32'h0);
        tick();
        #2;
        check_eq("rstw_stall_before", {31'b0, stall_m}, 32'h1);
        rst = 1'b0;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        check_eq("rstw_regwritew", {31'b0, regwritew}, 32'h0);
        check_eq("rstw_rd_w", {27'b0, rd_w}, 32'h0);
        check_eq("rstw_mem_err", {31'b0, mem_err}, 32'h0);
        check_eq("rstw_dmem_req", {31'b0, dmem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("rstw_stall_after", {31'b0, stall_m}, 32'h0);
        drive(1, 0, 1, 5'd11, 32'h1018, 32'h0, 32'h400, 1, 32'h12345678);
        #2;
        check_eq("rstw_ld_stall", {31'b0, stall_m}, 32'h0);
        tick();
        check_eq("rstw_ld_readdataw", readdataw, 32'h12345678);

`ifdef MEM_TIMEOUT_EN
        // Load that never completes: 4 stall cycles, then abandoned
        drive(1, 0, 1, 5'd3, 32'h2000, 32'h0, 32'h200, 0, 32'hAAAA5555);
        for (int i = 0; i < 4; i++) begin
            #2;
            check_eq("to_stall", {31'b0, stall_m}, 32'h1);
            tick();
            check_eq("to_bubble_regwritew", {31'b0, regwritew}, 32'h0);
        end
        #2;
        check_eq("to_abandon_stall", {31'b0, stall_m}, 32'h0);
        tick();
        check_eq("to_regwritew", {31'b0, regwritew}, 32'h0);
        check_eq("to_readdataw", readdataw, 32'h0);
        check_eq("to_alu_resultw", alu_resultw, 32'h200);
        check_eq("to_mem_err", {31'b0, mem_err}, 32'h1);
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        tick();
        check_eq("to_mem_err_sticky", {31'b0, mem_err}, 32'h1);
        rst = 1'b0;
        #1;
        check_eq("to_mem_err_rst", {31'b0, mem_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory (M) stage of the five-stage RISC-V pipeline. It consumes the EX/MEM register outputs of the execute stage, performs the load or store on the data memory through a valid/ready handshake, and registers the MEM/WB pipeline state for the writeback stage. When the data memory is slow, it raises a stall that freezes all upstream stages and inserts bubbles into writeback.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum WAIT cycles before an access is abandoned. Used only with `MEM_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `regwritem` input 1: instruction in M writes the register file.
- `memwritem` input 1: instruction in M is a store.
- `resultsrcm` input 1: instruction in M is a load; writeback selects read data.
- `rd_m` input 5: destination register.
- `pcplus4m` input 32: PC+4 of the instruction in M.
- `writedatam` input 32: store data, already forwarded.
- `alu_resultm` input 32: effective address or ALU result.
- `dmem_req` output 1: access request to the data memory.
- `dmem_we` output 1: write enable, qualified by `dmem_req`.
- `dmem_addr` output 32: byte address.
- `dmem_wdata` output 32: store data.
- `dmem_ready` input 1: memory accepts or completes the access this cycle.
- `dmem_rdata` input 32: load data, valid when `dmem_ready` is high.
- `stall_m` output 1: freeze the F, D, and E registers and the EX/MEM register.
- `regwritew` output 1: registered copy of `regwritem` for writeback.
- `resultsrcw` output 1: registered copy of `resultsrcm` for writeback.
- `rd_w` output 5: registered copy of `rd_m` for writeback.
- `pcplus4w` output 32: registered copy of `pcplus4m` for writeback.
- `alu_resultw` output 32: registered copy of `alu_resultm` for writeback.
- `readdataw` output 32: registered load data.
- `mem_err` output 1: sticky timeout flag.

## Operation
- An access is needed when `access = memwritem | resultsrcm`.
- The memory outputs are combinational: `dmem_req = access`, `dmem_we = memwritem`, `dmem_addr = alu_resultm`, `dmem_wdata = writedatam`.
- The stall is combinational: `stall_m = access & ~dmem_ready` (and not the timeout cycle; see Configuration).

FSM states are IDLE and WAIT.
- In IDLE with `access` high and `dmem_ready` low, the FSM moves to WAIT.
- In IDLE with `dmem_ready` high, the access completes in the same cycle and the FSM stays in IDLE.
- In WAIT, the request is held. Address, data, and write enable stay stable because upstream is frozen.
- When `dmem_ready` arrives in WAIT, the FSM returns to IDLE.

MEM/WB register:
- When `stall_m` is high, a bubble is loaded: `regwritew`=0, `resultsrcw`=0, and all other W outputs are 0.
- Otherwise, all M inputs are captured. `readdataw` captures `dmem_rdata` for a load and 0 for any other instruction.

Non-memory instructions pass through in one cycle with no request. A store completes on `dmem_ready`; its W copy has `regwritew` as decoded (normally 0).

Reset (`rst` low, at any time, including mid-WAIT):
- The FSM goes to IDLE, the counter to 0, all W outputs to 0, and `mem_err` to 0.
- A pending access is dropped.
- `dmem_req` follows the reset EX/MEM inputs, which are 0.

## Timing
- M-to-W latency is 1 cycle when `dmem_ready` is high in the request cycle.
- N cycles of memory wait add exactly N stall cycles and N W-stage bubbles.
- Back-to-back accesses need no idle cycle between them: the next request can issue in the cycle after `dmem_ready`.
- `dmem_ready` arriving while `access` is low is ignored.

## Configuration
With `MEM_TIMEOUT_EN` defined:
- A counter of width clog2(`TIMEOUT_CYCLES`+1) increments each WAIT cycle.
- On the cycle the counter reaches `TIMEOUT_CYCLES` without `dmem_ready`:
  - The access is abandoned and the FSM returns to IDLE.
  - `stall_m` drops for that cycle.
  - The W capture has `regwritew` forced to 0 and `readdataw` set to 0.
  - `mem_err` sets and stays high until reset.
- The counter clears whenever the FSM enters IDLE.

Without `MEM_TIMEOUT_EN`:
- No counter exists.
- The FSM waits indefinitely.
- `mem_err` is tied to 0.

## Structure
- The shared package `riscv_pipe_pkg` holds:
  - the memory-FSM state enum (IDLE, WAIT);
  - `XLEN`=32;
  - `REG_ADDR_W`=5;
  - the default `TIMEOUT_CYCLES`.
- One sub-module, `mem_access_ctrl`, contains the FSM, the stall logic, and the timeout counter.
- `memory_cycle` holds the MEM/WB register and the output assigns.

## Test plan
- ALU instruction (`regwritem`=1, `rd_m`=5, `alu_resultm`=0x2A) → `dmem_req`=0, `stall_m`=0; next cycle `rd_w`=5, `alu_resultw`=0x2A, `regwritew`=1.
- Load at 0x100 with `dmem_ready` high immediately and `dmem_rdata`=0xDEADBEEF → no stall; next cycle `readdataw`=0xDEADBEEF, `resultsrcw`=1.
- Store at 0x104, data 0x55, with `dmem_ready` delayed 3 cycles → `stall_m` high for 3 cycles with address and data held; 3 bubbles appear at W (`regwritew`=0); `dmem_we`=1 throughout.
- Reset pulled low during WAIT → W outputs and `mem_err` read 0 immediately; after release the FSM is in IDLE and `stall_m`=0.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, a load that never gets `dmem_ready` → 4 stall cycles, then `stall_m`=0, `regwritew`=0 at W, and `mem_err`=1 sticky.
